// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide sequencer.
// Holds widths, func3 encodings, FSM states and the special-case constants.
package ex_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
  typedef enum logic {STEP_MUL, STEP_DIV} step_mode_e;

  localparam logic [XLEN-1:0] DIV0_QUOT    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] NEG_ONE      = {XLEN{1'b1}};

  // Magnitude of a value that may be a negative two's-complement number.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_neg);
    return is_neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a
// {high, low} accumulator. Purely combinational.
module muldiv_step
  import ex_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  step_mode_e        mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          fits;

  // The 33-bit trial keeps the bit shifted out of the partial remainder.
  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    trial = acc[2*XLEN-1:XLEN-1];
    fits  = (trial >= {1'b0, operand});
    diff  = trial - {1'b0, operand};
    acc_next = '0;
    if (mode == STEP_MUL) begin
      if (acc[0]) acc_next = {sum, acc[XLEN-1:1]};
      else        acc_next = {1'b0, acc[2*XLEN-1:1]};
    end else begin
      if (fits) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else      acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage sequencer for RV32M ops: stalls the pipe for 32 iterations,
// finishes divide-by-zero and signed overflow early, aborts on flush.
module ex_muldiv_seq
  import ex_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  state_e            state;
  logic [2:0]        func3_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   result_q;
  logic              neg_q;
  logic              done_q;

  logic              is_rem, op1_signed, op2_signed, sign1, sign2;
  logic              div_zero, overflow, early, neg;
  logic [XLEN-1:0]   mag1, mag2, early_result, final_result, div_word;
  logic [2*XLEN-1:0] product;
  step_mode_e        step_mode;

  always_comb begin
    is_rem     = i_func3[2] & i_func3[1];
    op1_signed = (i_func3 == F3_MULH) || (i_func3 == F3_MULHSU) ||
                 (i_func3 == F3_DIV)  || (i_func3 == F3_REM);
    op2_signed = (i_func3 == F3_MULH) || (i_func3 == F3_DIV) || (i_func3 == F3_REM);
    sign1      = op1_signed & i_op1[XLEN-1];
    sign2      = op2_signed & i_op2[XLEN-1];
    mag1       = abs_val(i_op1, sign1);
    mag2       = abs_val(i_op2, sign2);
    div_zero   = i_func3[2] && (i_op2 == '0);
    overflow   = ((i_func3 == F3_DIV) || (i_func3 == F3_REM)) &&
                 (i_op1 == OVF_DIVIDEND) && (i_op2 == NEG_ONE);
    early      = div_zero | overflow;
    neg        = is_rem ? sign1 : (sign1 ^ sign2);
    early_result = '0;
    if (div_zero)      early_result = is_rem ? i_op1 : DIV0_QUOT;
    else if (overflow) early_result = is_rem ? '0 : OVF_DIVIDEND;
  end

  assign step_mode = func3_q[2] ? STEP_DIV : STEP_MUL;

  muldiv_step u_step (
    .acc      (acc),
    .operand  (operand),
    .mode     (step_mode),
    .acc_next (acc_next)
  );

  // The final iteration's output is used directly so the result loads on the same edge.
  always_comb begin
    product  = neg_q ? (~acc_next + 1'b1) : acc_next;
    div_word = func3_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (!func3_q[2])
      final_result = (func3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    else
      final_result = neg_q ? (~div_word + 1'b1) : div_word;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      func3_q  <= '0;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_valid) begin
              if (early) begin
                result_q <= early_result;
                done_q   <= 1'b1;
                state    <= DONE;
              end else begin
                func3_q <= i_func3;
                acc     <= {{XLEN{1'b0}}, mag1};
                operand <= mag2;
                neg_q   <= neg;
                cnt     <= '0;
                state   <= ITER;
              end
            end
          end
          ITER: begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) begin
              result_q <= final_result;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_stall  = ((state == IDLE) & i_valid & ~i_flush & ~early) | (state == ITER);
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: arithmetic reference model, per-cycle
// compare of stall/busy/done/result, directed literal cases plus random traffic.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  func3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic        check_en  = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        exp_done  = 1'b0;
  logic [31:0] exp_result = '0;
  logic [31:0] model_res  = '0;

  ex_muldiv_seq dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_func3  (func3),
    .i_op1    (op1),
    .i_op2    (op2),
    .i_flush  (flush),
    .o_stall  (stall),
    .o_done   (done),
    .o_result (result),
    .o_busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural RV32M result computed with wide plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic        [63:0] up;
    logic signed [31:0] q;
    sa = {{32{a[31]}}, a};
    sb = (f == 3'b010) ? {32'b0, b} : {{32{b[31]}}, b};
    p  = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    case (f)
      3'b000: return up[31:0];
      3'b001, 3'b010: return p[63:32];
      3'b011: return up[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stall",  {31'b0, stall}, {31'b0, exp_stall});
      checkOutput("busy",   {31'b0, busy},  {31'b0, exp_busy});
      checkOutput("done",   {31'b0, done},  {31'b0, exp_done});
      checkOutput("result", result, exp_result);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b0; flush = 1'b0;
      exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_result = model_res;
      step();
    end
  endtask

  // Issues one op (valid held until DONE); flush_at in 1..32 squashes it in that ITER cycle.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input int flush_at, input bit use_lit, input logic [31:0] lit,
                               input string name);
    logic [31:0] expv;
    bit early;
    early = f[2] && (b == 0 || ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    expv  = ref_result(f, a, b);
    valid = 1'b1; func3 = f; op1 = a; op2 = b; flush = 1'b0;
    exp_stall = !early; exp_busy = 1'b0; exp_done = 1'b0; exp_result = model_res;
    step();
    if (!early) begin
      for (int i = 1; i <= 32; i++) begin
        exp_stall = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
        if (i == flush_at) begin
          flush = 1'b1;
          step();
          flush = 1'b0; valid = 1'b0;
          exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
          step();
          return;
        end
        step();
      end
    end
    model_res = expv;
    exp_stall = 1'b0; exp_busy = 1'b1; exp_done = 1'b1; exp_result = expv;
    #2;
    if (use_lit) checkOutput(name, result, lit);
    step();
    valid = 1'b0;
    exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return $urandom_range(0, 20);
      4:       return 32'h0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    applyStimulus(3'b000, 32'd6, 32'd7, 0, 1'b1, 32'd42, "mul_6x7");
    applyStimulus(3'b000, 32'd5, 32'd9, 10, 1'b0, '0, "mul_flushed");
    applyStimulus(3'b000, 32'd3, 32'd3, 0, 1'b1, 32'd9, "mul_3x3_after_flush");
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 0, 1'b1, 32'hFFFFFFFD, "div_m7_2");
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 0, 1'b1, 32'hFFFFFFFF, "rem_m7_2");
    applyStimulus(3'b101, 32'd100, 32'd7, 0, 1'b1, 32'd14, "divu_100_7");
    applyStimulus(3'b111, 32'd100, 32'd7, 0, 1'b1, 32'd2, "remu_100_7");
    idleCycles(2);
    applyStimulus(3'b101, 32'h1234, 32'h0, 0, 1'b1, 32'hFFFFFFFF, "divu_by_zero");
    applyStimulus(3'b110, 32'h1234, 32'h0, 0, 1'b1, 32'h1234, "rem_by_zero");
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h80000000, "div_overflow");
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h0, "rem_overflow");
    applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'h0, "mulh_m1");
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'hFFFFFFFE, "mulhu_max");
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'hFFFFFFFF, "mulhsu_m1");
    applyStimulus(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'h1, "mul_m1");
    applyStimulus(3'b101, 32'd77, 32'd5, 32, 1'b0, '0, "divu_flush_last");
    idleCycles(1);

    // Reset in the middle of an iteration: outputs clear at once, no stale done.
    valid = 1'b1; func3 = 3'b000; op1 = 32'd11; op2 = 32'd13;
    exp_stall = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_result = model_res;
    step();
    for (int i = 0; i < 5; i++) begin
      exp_busy = 1'b1;
      step();
    end
    rst = 1'b1; valid = 1'b0;
    model_res = '0;
    exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_result = '0;
    #1;
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    step();
    rst = 1'b0;
    idleCycles(40);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      int          fa;
      rf = 3'($urandom_range(0, 7));
      ra = pickOperand();
      rb = pickOperand();
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 32)) : 0;
      applyStimulus(rf, ra, rb, fa, 1'b0, '0, "random");
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(2);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
